// File: rtl/slave_mem_dut_if.sv
// Pin-level request/response bus between a transaction master and a memory slave.
// The master drives the request side; the slave returns ack/err and read data.
interface pin_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DW         = 8
);
  logic                  req;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] address;
  logic [DW-1:0]         wr_data;
  logic [DW-1:0]         rd_data;
  logic                  ack;
  logic                  err;

  modport master_mp (output req, rw, address, wr_data, input rd_data, ack, err);
  modport slave_mp  (input req, rw, address, wr_data, output rd_data, ack, err);
endinterface

// File: rtl/slave_mem_dut.sv
// Memory-backed bus slave with programmable wait states and out-of-range error response.
// The request is latched in IDLE, so bus changes after sampling do not affect the response.
module slave_mem_dut #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DW          = 8,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  pin_if.slave_mp     bus,
  output logic [15:0] txn_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic [AW-1:0]       r_addr;
  logic                r_rw;
  logic [DW-1:0]       r_wdata;
  logic                r_in_range;
  logic                r_ack, r_err;
  logic [DW-1:0]       r_rd_data;
  logic [15:0]         r_txn;
  logic [DW-1:0]       r_mem [DEPTH];

  logic [ADDR_WIDTH:0] w_off;
  logic                w_in_range;
  logic                w_accept;
  logic                w_wait_done;

  // One extra bit so addresses below BASE_ADDR wrap to a large value and fail the range test.
  assign w_off       = {1'b0, bus.address} - {1'b0, BASE_ADDR};
  assign w_in_range  = w_off < (ADDR_WIDTH+1)'(DEPTH);
  assign w_accept    = (r_state == S_IDLE) && bus.req;
  assign w_wait_done = (r_cnt == 4'(WAIT_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.req) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: begin
        if (!bus.req)        w_next = S_IDLE;
        else if (w_wait_done) w_next = S_RESP;
      end
      S_RESP: w_next = S_DONE;
      S_DONE: if (!bus.req) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_wdata    <= '0;
      r_in_range <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rd_data  <= '0;
      r_txn      <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= (r_state == S_WAIT && w_next == S_WAIT) ? r_cnt + 4'd1 : 4'd0;
      if (w_accept) begin
        r_addr     <= w_off[AW-1:0];
        r_rw       <= bus.rw;
        r_wdata    <= bus.wr_data;
        r_in_range <= w_in_range;
      end
      // Response registers load on the edge leaving RESP, so ack/err last exactly one cycle.
      if (r_state == S_RESP) begin
        r_ack <= r_in_range;
        r_err <= !r_in_range;
        if (r_in_range && r_rw) r_rd_data <= r_mem[r_addr];
        if (r_txn != 16'hFFFF) r_txn <= r_txn + 16'd1;
      end
    end
  end

  // Storage has no reset so contents survive rst; a reset edge still blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_RESP && r_in_range && !r_rw)
      r_mem[r_addr] <= r_wdata;
  end

  assign bus.ack     = r_ack;
  assign bus.err     = r_err;
  assign bus.rd_data = r_rd_data;
  assign txn_count   = r_txn;
endmodule

// File: tb/tb_slave_mem_dut.sv
// Directed bench for slave_mem_dut: two instances (2 wait states at base 0, 0 wait states at base 0x0100).
// Table-driven transactions plus hand sequences for hold, abort and mid-transaction reset.
module tb_slave_mem_dut;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cnt0, cnt1;
  int          total = 0;
  int          bad   = 0;
  bit          sel   = 1'b0;

  pin_if #(.ADDR_WIDTH(16), .DW(8)) if0 ();
  pin_if #(.ADDR_WIDTH(16), .DW(8)) if1 ();

  slave_mem_dut #(.WAIT_CYCLES(2), .BASE_ADDR(16'h0000)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave_mp), .txn_count(cnt0));
  slave_mem_dut #(.WAIT_CYCLES(0), .BASE_ADDR(16'h0100)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave_mp), .txn_count(cnt1));

  always #5 clk = ~clk;

  logic        m_ack, m_err;
  logic [7:0]  m_rd;
  logic [15:0] m_cnt;
  always_comb begin
    m_ack = sel ? if1.ack     : if0.ack;
    m_err = sel ? if1.err     : if0.err;
    m_rd  = sel ? if1.rd_data : if0.rd_data;
    m_cnt = sel ? cnt1        : cnt0;
  end

  typedef struct {
    bit          sel;
    bit          rw;
    logic [15:0] addr;
    logic [7:0]  wd;
    bit          eack;
    bit          eerr;
    logic [7:0]  erd;
    int          ecnt;
    int          elat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit s, input bit req, input bit rw, input logic [15:0] a, input logic [7:0] d);
    if (s) begin
      if1.req = req; if1.rw = rw; if1.address = a; if1.wr_data = d;
    end else begin
      if0.req = req; if0.rw = rw; if0.address = a; if0.wr_data = d;
    end
  endtask

  function automatic vec_t mk(bit s, bit rw, logic [15:0] a, logic [7:0] d,
                              bit ea, bit ee, logic [7:0] erd, int ec);
    vec_t v;
    v.sel = s; v.rw = rw; v.addr = a; v.wd = d;
    v.eack = ea; v.eerr = ee; v.erd = erd; v.ecnt = ec;
    v.elat = s ? 1 : 3;
    return v;
  endfunction

  // Called at a negedge with the target slave in IDLE; returns at a negedge with it back in IDLE.
  task automatic run_txn(input vec_t v, input string tag);
    int lat;
    sel = v.sel;
    drive(v.sel, 1'b1, v.rw, v.addr, v.wd);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_ack || m_err) begin lat = k; break; end
    end
    chk({tag, ".lat"}, lat,   v.elat);
    chk({tag, ".ack"}, m_ack, v.eack);
    chk({tag, ".err"}, m_err, v.eerr);
    chk({tag, ".rd"},  m_rd,  v.erd);
    chk({tag, ".cnt"}, m_cnt, v.ecnt);
    @(negedge clk);
    chk({tag, ".one_cycle"}, {m_ack, m_err}, 2'b00);
    drive(v.sel, 1'b0, v.rw, v.addr, v.wd);
    @(negedge clk);
  endtask

  initial begin
    int n;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.ack0", if0.ack, 1'b0);
    chk("rst.err0", if0.err, 1'b0);
    chk("rst.rd0",  if0.rd_data, 8'h00);
    chk("rst.cnt0", cnt0, 16'h0);
    chk("rst.ack1", if1.ack, 1'b0);
    chk("rst.cnt1", cnt1, 16'h0);
    rst = 1'b0;
    @(negedge clk);

    //               sel rw addr      wd     ack err rd     cnt
    tbl.push_back(mk(0, 0, 16'h0010, 8'hA5, 1, 0, 8'h00, 1));
    tbl.push_back(mk(0, 1, 16'h0010, 8'h00, 1, 0, 8'hA5, 2));
    tbl.push_back(mk(0, 1, 16'h0100, 8'h00, 0, 1, 8'hA5, 3));
    tbl.push_back(mk(0, 0, 16'h00FF, 8'h5A, 1, 0, 8'hA5, 4));
    tbl.push_back(mk(0, 1, 16'h00FF, 8'h00, 1, 0, 8'h5A, 5));
    tbl.push_back(mk(0, 1, 16'hFFFF, 8'h00, 0, 1, 8'h5A, 6));
    tbl.push_back(mk(0, 0, 16'h0020, 8'h11, 1, 0, 8'h5A, 7));
    tbl.push_back(mk(0, 1, 16'h0020, 8'h00, 1, 0, 8'h11, 8));
    tbl.push_back(mk(0, 0, 16'h0030, 8'h77, 1, 0, 8'h11, 9));
    tbl.push_back(mk(1, 0, 16'h01FF, 8'hC3, 1, 0, 8'h00, 1));
    tbl.push_back(mk(1, 1, 16'h01FF, 8'h00, 1, 0, 8'hC3, 2));
    tbl.push_back(mk(1, 1, 16'h00FF, 8'h00, 0, 1, 8'hC3, 3));
    tbl.push_back(mk(1, 1, 16'h0200, 8'h00, 0, 1, 8'hC3, 4));
    tbl.push_back(mk(1, 0, 16'h0100, 8'h0F, 1, 0, 8'hC3, 5));
    tbl.push_back(mk(1, 1, 16'h0100, 8'h00, 1, 0, 8'h0F, 6));
    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

    // req held high long after the response: exactly one ack
    sel = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 16'h0010, 8'h00);
    n = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (if0.ack || if0.err) n++;
    end
    chk("hold.acks", n, 1);
    chk("hold.cnt", cnt0, 16'd10);
    drive(1'b0, 1'b0, 1'b1, 16'h0010, 8'h00);
    @(negedge clk);
    run_txn(mk(0, 1, 16'h0010, 8'h00, 1, 0, 8'hA5, 11), "after_hold");

    // write dropped during WAIT: no response, no write
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 8'h3C);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0020, 8'h3C);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if0.ack || if0.err) n++;
    end
    chk("abort.resp", n, 0);
    chk("abort.cnt", cnt0, 16'd11);
    run_txn(mk(0, 1, 16'h0020, 8'h00, 1, 0, 8'h11, 12), "abort_rd");

    // reset pulse while a read is in WAIT
    drive(1'b0, 1'b1, 1'b1, 16'h0030, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 16'h0030, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.ack", if0.ack, 1'b0);
    chk("mrst.err", if0.err, 1'b0);
    chk("mrst.rd",  if0.rd_data, 8'h00);
    chk("mrst.cnt", cnt0, 16'h0);
    chk("mrst.cnt1", cnt1, 16'h0);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (if0.ack || if0.err) n++;
    end
    chk("mrst.noresp", n, 0);
    run_txn(mk(0, 1, 16'h0030, 8'h00, 1, 0, 8'h77, 1), "mrst_rd");
    run_txn(mk(1, 1, 16'h01FF, 8'h00, 1, 0, 8'hC3, 1), "mrst_rd1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
